path_capture_deserializer: RTL and testbench
============================================

Name: path_capture_deserializer

Overview:
- Downstream consumer of the internal-path register chain.
- Takes the 1-bit registered stream launched and captured on clk, assembles it into WIDTH-bit words, and presents each word on a valid/ready output port.
- A one-entry output holding register decouples assembly from the consumer; loss of a word is flagged, never silent.
- Gives timing examples a realistic capture side: a shift register, a counter, a small FSM and a handshake, all on one clock.

Parameters:
- WIDTH, 8, bits per assembled word (legal range 2..32).
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  single clock, all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- in  input  1  serial data bit from the upstream capture flop.
- in_valid  input  1  qualifies in; a bit is consumed on each rising clk edge where in_valid=1.
- frame_clr  input  1  synchronous discard of the partial word; bit counter returns to 0.
- out_data  output  WIDTH  assembled word; first received bit is in bit 0 (LSB-first).
- out_valid  output  1  holding register contains a word.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid & out_ready.
- overrun  output  1  sticky; set when a completed word is dropped.
- word_count  output  CNT_W  number of words delivered to the holding register, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shift register, bit counter, out_data, out_valid, overrun and word_count all go to 0.
  - FSM goes to ASSEMBLE.
- Assembly:
  - On each in_valid cycle, in is written at position bit_cnt of the shift register and bit_cnt increments.
  - bit_cnt has width clog2(WIDTH).
- Word completion: in_valid=1 with bit_cnt=WIDTH-1 completes a word; bit_cnt returns to 0 in the same cycle.
- Holding FSM has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY + word completes -> FULL next cycle. out_data is the completed word, including the bit arriving this cycle. word_count increments.
  - FULL + out_ready=1, no completion -> EMPTY.
  - FULL + out_ready=1 + completion in the same cycle -> stay FULL. The new word replaces out_data and word_count increments. There is no bubble and no overrun.
  - FULL + out_ready=0 + completion -> stay FULL. out_data is unchanged, the new word is dropped, overrun is set to 1, and word_count does not increment.
- Latency: the last bit of a word is sampled on edge N; out_valid=1 with that word is visible after edge N (one cycle).
- out_data is stable while out_valid=1 and out_ready=0.
- frame_clr:
  - Has priority over in_valid in the same cycle: the bit is discarded and bit_cnt goes to 0.
  - Does not affect the holding register, word_count or overrun.
- overrun clears only on reset.
- word_count wraps from 2^CNT_W-1 to 0 without any flag.
- Reset mid-word or mid-handshake abandons all state immediately; no partial word is emitted after reset.
- Gaps in in_valid are allowed at any bit position and leave the assembly state untouched.

Decomposition:
- Shared package path_capture_pkg holds:
  - the FSM state enum (ST_EMPTY, ST_FULL);
  - the WIDTH legality limits;
  - a function clog2_min1 returning max(1, clog2(WIDTH)).
- One natural sub-module, serial_shift_assembler. It owns the shift register, bit_cnt and frame_clr handling, and outputs word plus word_done.
- The top level owns the holding FSM, overrun and word_count.

Test Plan:
- Reset then stream 8 bits 1,0,1,1,0,0,0,1 with in_valid=1 and out_ready=1 -> one cycle after the 8th bit: out_valid=1, out_data=8'h8D, word_count=1, overrun=0.
- Same stream with in_valid toggling 1,0 every cycle -> identical out_data=8'h8D; completion occurs after 15 cycles instead of 8.
- Hold out_ready=0 and send two words, 8'hA5 then 8'h3C -> out_data stays 8'hA5, overrun=1 after the 16th bit, word_count=1.
- out_ready=1 asserted exactly on the completion edge of the second word (8'h3C) while the first (8'hA5) is held -> 8'hA5 transfers, out_data=8'h3C, out_valid stays 1, overrun=0, word_count=2.
- Send 5 bits, pulse frame_clr together with a 6th bit, then send 8 bits of 8'hFF -> out_data=8'hFF; no word is formed from the discarded bits.
- Assert rst_n=0 asynchronously (between edges) after 4 bits of a word with out_valid=1 -> out_valid, overrun and word_count are 0 immediately; the next 8 bits of 8'h01 yield out_data=8'h01.

Source files
------------

// File: rtl/path_capture_pkg.sv
// Shared definitions for the path-capture deserializer: holding-FSM states,
// legal word-width limits and a counter-width helper.
package path_capture_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Width of a counter that indexes 0..w-1, never narrower than one bit.
    function automatic int clog2_min1(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << r) < 64'(w)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_shift_assembler.sv
// Collects the qualified serial stream LSB-first into a WIDTH-bit word and
// flags the cycle in which the last bit of a word arrives.
module serial_shift_assembler
    import path_capture_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int CW = clog2_min1(WIDTH);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    bit_cnt_reg;
    logic [CW-1:0]    bit_cnt_next;
    logic             take;

    // A frame clear discards the bit offered in the same cycle.
    assign take      = in_valid & ~frame_clr;
    assign word_done = take && (bit_cnt_reg == CW'(WIDTH - 1));

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic hit;
            assign hit            = take && (bit_cnt_reg == CW'(gi));
            assign shift_next[gi] = hit ? in : shift_reg[gi];
        end
    endgenerate

    // The completed word includes the bit arriving this cycle.
    assign word = shift_next;

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (frame_clr) begin
            bit_cnt_next = '0;
        end else if (take) begin
            bit_cnt_next = word_done ? '0 : bit_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

endmodule

// File: rtl/path_capture_deserializer.sv
// Serial-to-parallel capture stage: assembles words and hands them out through a
// one-entry holding register with valid/ready, a sticky overrun flag and a word counter.
module path_capture_deserializer
    import path_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] word_count
);

    hold_state_t      state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             overrun_reg, overrun_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] word;
    logic             word_done;

    serial_shift_assembler #(
        .WIDTH(WIDTH)
    ) u_assembler (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .in_valid (in_valid),
        .frame_clr(frame_clr),
        .word     (word),
        .word_done(word_done)
    );

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        overrun_next = overrun_reg;
        count_next   = count_reg;
        unique case (state_reg)
            ST_EMPTY: begin
                if (word_done) begin
                    state_next = ST_FULL;
                    data_next  = word;
                    count_next = count_reg + CNT_W'(1);
                end
            end
            ST_FULL: begin
                if (word_done && out_ready) begin
                    // Old word leaves and new word lands on the same edge: no bubble.
                    data_next  = word;
                    count_next = count_reg + CNT_W'(1);
                end else if (word_done) begin
                    overrun_next = 1'b1;
                end else if (out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_EMPTY;
            data_reg    <= '0;
            overrun_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            overrun_reg <= overrun_next;
            count_reg   <= count_next;
        end
    end

    assign out_data   = data_reg;
    assign out_valid  = (state_reg == ST_FULL);
    assign overrun    = overrun_reg;
    assign word_count = count_reg;

endmodule

// File: tb/tb_path_capture_deserializer.sv
// Directed and randomized checks of path_capture_deserializer against a
// bit-queue reference model of word assembly and the one-entry holding register.
module tb_path_capture_deserializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in = 1'b0;
    logic             in_valid = 1'b0;
    logic             frame_clr = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic [CNT_W-1:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit               m_bits[$];
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    bit               m_overrun;
    int               m_count;

    path_capture_deserializer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .frame_clr (frame_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
        check({tag, ".count"}, 32'(word_count), 32'(m_count));
        if (m_valid) check({tag, ".data"}, 32'(out_data), 32'(m_data));
    endtask

    task automatic model_edge(input bit b, input bit v, input bit fc, input bit rdy);
        bit               done;
        logic [WIDTH-1:0] w;
        done = 1'b0;
        w    = '0;
        if (fc) begin
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() == WIDTH) begin
                done = 1'b1;
                foreach (m_bits[i]) w[i] = m_bits[i];
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = w;
                m_count = (m_count + 1) % (1 << CNT_W);
                $display("word %02h delivered, count=%0d", w, m_count);
            end else begin
                m_overrun = 1'b1;
                $display("word %02h dropped (holding register full)", w);
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock cycle: drive, clock, update model, then compare 1 time unit later.
    task automatic step(input bit b, input bit v, input bit fc, input bit rdy, input string tag);
        in = b; in_valid = v; frame_clr = fc; out_ready = rdy;
        @(posedge clk);
        model_edge(b, v, fc, rdy);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        in = 1'b0; in_valid = 1'b0; frame_clr = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_bits.delete();
        m_valid = 1'b0; m_data = '0; m_overrun = 1'b0; m_count = 0;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.count", 32'(word_count), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input bit rdy_last,
                             input bit gap, input string tag);
        for (int i = 0; i < WIDTH; i++) begin
            step(w[i], 1'b1, 1'b0, (i == WIDTH - 1) ? rdy_last : rdy, tag);
            if (gap && i < WIDTH - 1) step(1'b0, 1'b0, 1'b0, rdy, tag);
        end
    endtask

    initial begin
        int cycles;

        do_reset();

        // Plain stream 1,0,1,1,0,0,0,1
        send_word(8'h8D, 1'b1, 1'b1, 1'b0, "plain");
        check("plain.data_8D", 32'(out_data), 32'h8D);
        check("plain.valid", 32'(out_valid), 32'd1);
        check("plain.count1", 32'(word_count), 32'd1);
        check("plain.no_overrun", 32'(overrun), 32'd0);

        // Same word with in_valid gaps: completes on the 15th cycle
        do_reset();
        cycles = 0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] w;
            w = 8'h8D;
            step(w[i], 1'b1, 1'b0, 1'b1, "gap");
            cycles++;
            if (cycles == 14) check("gap.not_yet", 32'(out_valid), 32'd0);
            if (i < WIDTH - 1) begin
                step(1'b0, 1'b0, 1'b0, 1'b1, "gap");
                cycles++;
                if (cycles == 14) check("gap.not_yet", 32'(out_valid), 32'd0);
            end
        end
        check("gap.cycles", 32'(cycles), 32'd15);
        check("gap.data_8D", 32'(out_data), 32'h8D);
        check("gap.valid", 32'(out_valid), 32'd1);

        // Consumer stalled: second word is dropped
        do_reset();
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, "stall");
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, "stall");
        check("stall.data_A5", 32'(out_data), 32'hA5);
        check("stall.overrun", 32'(overrun), 32'd1);
        check("stall.count1", 32'(word_count), 32'd1);

        // Ready arrives exactly on the completion edge of the second word
        do_reset();
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, "swap");
        send_word(8'h3C, 1'b0, 1'b1, 1'b0, "swap");
        check("swap.data_3C", 32'(out_data), 32'h3C);
        check("swap.valid", 32'(out_valid), 32'd1);
        check("swap.no_overrun", 32'(overrun), 32'd0);
        check("swap.count2", 32'(word_count), 32'd2);

        // Partial word discarded by frame_clr (which beats a 6th bit)
        do_reset();
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, "clr");
        step(1'b0, 1'b1, 1'b1, 1'b1, "clr");
        check("clr.count0", 32'(word_count), 32'd0);
        send_word(8'hFF, 1'b1, 1'b1, 1'b0, "clr");
        check("clr.data_FF", 32'(out_data), 32'hFF);
        check("clr.count1", 32'(word_count), 32'd1);

        // Asynchronous reset mid-word with a word held
        do_reset();
        send_word(8'h5A, 1'b0, 1'b0, 1'b0, "arst");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "arst");
        do_reset();
        send_word(8'h01, 1'b1, 1'b1, 1'b0, "arst");
        check("arst.data_01", 32'(out_data), 32'h01);
        check("arst.count1", 32'(word_count), 32'd1);

        // Randomized traffic; the narrow counter wraps several times
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
